// File: rtl/hll_pkg.sv
// Shared constants, FSM state type and rank-input helper for the HLL bucket controller.
package hll_pkg;

    localparam int unsigned RANK_W      = 5;
    localparam int unsigned LZC_LATENCY = 8;
    localparam int unsigned HASH_W      = 32;

    typedef enum logic [1:0] {
        CLEAR,
        RUN,
        DRAIN,
        READ
    } hll_state_t;

    // Drops the index bits and appends a sentinel 1 so the rank saturates at 33-p.
    function automatic logic [HASH_W-1:0] rank_input(input logic [HASH_W-1:0] hash,
                                                     input int unsigned p);
        return (hash << p) | (HASH_W'(1) << (p - 1));
    endfunction

endpackage

// File: rtl/hll_bucket_ctrl_if.sv
// Hash input stream, flush pulse and bucket readout stream of the HLL bucket controller.
interface hll_bucket_ctrl_if;
    import hll_pkg::*;

    logic [HASH_W-1:0] hash_data;
    logic              hash_valid;
    logic              hash_ready;
    logic              flush;
    logic [RANK_W-1:0] bucket_data;
    logic              bucket_valid;
    logic              bucket_ready;
    logic              bucket_last;
    logic              busy;

    modport master (
        output hash_data, hash_valid, flush, bucket_ready,
        input  hash_ready, bucket_data, bucket_valid, bucket_last, busy
    );

    modport slave (
        input  hash_data, hash_valid, flush, bucket_ready,
        output hash_ready, bucket_data, bucket_valid, bucket_last, busy
    );

endinterface

// File: rtl/hll_bucket_ram.sv
// Simple dual-port bucket RAM, 1-cycle synchronous read, read-first on address collision.
module hll_bucket_ram #(
    parameter int unsigned P = 14,
    parameter int unsigned W = 5
) (
    input  logic         clk,
    input  logic         we,
    input  logic [P-1:0] waddr,
    input  logic [W-1:0] wdata,
    input  logic [P-1:0] raddr,
    output logic [W-1:0] rdata
);

    logic [W-1:0] mem [2**P];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/leftmost_bit_0.sv
// Fixed-latency rank unit: 1-based position of the leftmost set bit, counted from the MSB.
module leftmost_bit_0 #(
    parameter int unsigned W       = 32,
    parameter int unsigned RW      = 6,
    parameter int unsigned LATENCY = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [W-1:0]  data_in,
    input  logic          valid_in,
    output logic [RW-1:0] rank,
    output logic          valid_out
);

    logic [RW-1:0]      lead;
    logic               found;
    logic [RW-1:0]      rank_q [LATENCY];
    logic [LATENCY-1:0] valid_q;

    always_comb begin
        lead  = RW'(1);
        found = 1'b0;
        for (int unsigned i = 0; i < W; i++) begin
            if (!found) begin
                if (data_in[W-1-i]) found = 1'b1;
                else                lead  = lead + RW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            for (int unsigned i = 0; i < LATENCY; i++) rank_q[i] <= '0;
        end else begin
            valid_q   <= {valid_q[LATENCY-2:0], valid_in};
            rank_q[0] <= lead;
            for (int unsigned i = 1; i < LATENCY; i++) rank_q[i] <= rank_q[i-1];
        end
    end

    assign rank      = rank_q[LATENCY-1];
    assign valid_out = valid_q[LATENCY-1];

endmodule

// File: rtl/hll_bucket_ctrl.sv
// HyperLogLog bucket controller: clear, max-rank accumulate with forwarding, drain, readout.
module hll_bucket_ctrl
    import hll_pkg::*;
#(
    parameter int unsigned P = 14
) (
    input logic              clk,
    input logic              rst,
    hll_bucket_ctrl_if.slave bus
);

    hll_state_t state, state_next;
    logic [P-1:0] addr;
    logic         rd_done;
    logic         busy_q;
    logic         rd_issue;

    logic              accept;
    logic [HASH_W-1:0] rank_in;
    logic [RANK_W-1:0] rank;
    logic              rank_valid;

    logic [P-1:0]           dl_idx [LZC_LATENCY];
    logic [LZC_LATENCY-1:0] dl_valid;

    logic              b_valid, fwd_valid;
    logic [P-1:0]      b_idx, fwd_idx;
    logic [RANK_W-1:0] b_rank, fwd_data, b_old, b_new;

    logic              ram_we;
    logic [P-1:0]      ram_waddr, ram_raddr;
    logic [RANK_W-1:0] ram_wdata, ram_rdata;

    logic [RANK_W-1:0] buf_data [2];
    logic [1:0]        buf_last;
    logic [1:0]        buf_cnt, occ_after;
    logic              rd_pend, rd_pend_last, push, pop;

    assign accept  = bus.hash_valid && bus.hash_ready;
    assign rank_in = rank_input(bus.hash_data, P);

    leftmost_bit_0 #(.W(HASH_W), .RW(RANK_W), .LATENCY(LZC_LATENCY)) u_lzc (
        .clk       (clk),
        .rst       (rst),
        .data_in   (rank_in),
        .valid_in  (accept),
        .rank      (rank),
        .valid_out (rank_valid)
    );

    hll_bucket_ram #(.P(P), .W(RANK_W)) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (ram_wdata),
        .raddr (ram_raddr),
        .rdata (ram_rdata)
    );

    assign push      = rd_pend;
    assign pop       = bus.bucket_valid && bus.bucket_ready;
    assign occ_after = buf_cnt + 2'(push) - 2'(pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= CLEAR;
            busy_q <= 1'b1;
        end else begin
            state  <= state_next;
            busy_q <= (state_next != RUN);
        end
    end

    always_comb begin
        state_next = state;
        rd_issue   = 1'b0;
        case (state)
            CLEAR: if (&addr) state_next = RUN;
            RUN:   if (bus.flush) state_next = DRAIN;
            DRAIN: if (!(|dl_valid) && !b_valid) state_next = READ;
            READ: begin
                // Issue only if the in-flight read is guaranteed a free buffer slot.
                rd_issue = !rd_done && (occ_after < 2'd2);
                if (pop && buf_last[0]) state_next = CLEAR;
            end
            default: state_next = CLEAR;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr    <= '0;
            rd_done <= 1'b0;
        end else begin
            if (state == CLEAR || rd_issue) addr <= addr + P'(1);
            if (rd_issue && (&addr)) rd_done <= 1'b1;
            if (state == READ && state_next == CLEAR) rd_done <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dl_valid <= '0;
            for (int unsigned i = 0; i < LZC_LATENCY; i++) dl_idx[i] <= '0;
        end else begin
            dl_valid  <= {dl_valid[LZC_LATENCY-2:0], accept};
            dl_idx[0] <= bus.hash_data[HASH_W-1 -: P];
            for (int unsigned i = 1; i < LZC_LATENCY; i++) dl_idx[i] <= dl_idx[i-1];
        end
    end

    // Previous cycle's write is not yet visible through the read-first RAM, so forward it.
    always_comb begin
        b_old = (fwd_valid && fwd_idx == b_idx) ? fwd_data : ram_rdata;
        b_new = (b_old > b_rank) ? b_old : b_rank;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            b_valid   <= 1'b0;
            b_idx     <= '0;
            b_rank    <= '0;
            fwd_valid <= 1'b0;
            fwd_idx   <= '0;
            fwd_data  <= '0;
        end else begin
            b_valid   <= rank_valid;
            b_idx     <= dl_idx[LZC_LATENCY-1];
            b_rank    <= rank;
            fwd_valid <= b_valid;
            fwd_idx   <= b_idx;
            fwd_data  <= b_new;
        end
    end

    always_comb begin
        ram_raddr = (state == READ) ? addr : dl_idx[LZC_LATENCY-1];
        if (state == CLEAR) begin
            ram_we    = 1'b1;
            ram_waddr = addr;
            ram_wdata = '0;
        end else begin
            ram_we    = b_valid;
            ram_waddr = b_idx;
            ram_wdata = b_new;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_pend      <= 1'b0;
            rd_pend_last <= 1'b0;
            buf_cnt      <= '0;
            buf_last     <= '0;
            buf_data[0]  <= '0;
            buf_data[1]  <= '0;
        end else begin
            rd_pend      <= rd_issue;
            rd_pend_last <= rd_issue && (&addr);
            case ({push, pop})
                2'b10: begin
                    if (buf_cnt == 2'd0) begin
                        buf_data[0] <= ram_rdata;
                        buf_last[0] <= rd_pend_last;
                    end else begin
                        buf_data[1] <= ram_rdata;
                        buf_last[1] <= rd_pend_last;
                    end
                    buf_cnt <= buf_cnt + 2'd1;
                end
                2'b01: begin
                    buf_data[0] <= buf_data[1];
                    buf_last[0] <= buf_last[1];
                    buf_cnt     <= buf_cnt - 2'd1;
                end
                2'b11: begin
                    if (buf_cnt == 2'd1) begin
                        buf_data[0] <= ram_rdata;
                        buf_last[0] <= rd_pend_last;
                    end else begin
                        buf_data[0] <= buf_data[1];
                        buf_last[0] <= buf_last[1];
                        buf_data[1] <= ram_rdata;
                        buf_last[1] <= rd_pend_last;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.hash_ready   = (state == RUN);
    assign bus.busy         = busy_q;
    assign bus.bucket_valid = (buf_cnt != 2'd0);
    assign bus.bucket_data  = buf_data[0];
    assign bus.bucket_last  = buf_last[0];

endmodule

// File: tb/tb_hll_bucket_ctrl.sv
// Randomized self-checking bench for hll_bucket_ctrl (P=4) against a per-bucket max model.
module tb_hll_bucket_ctrl;

    localparam int unsigned P  = 4;
    localparam int          NB = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    hll_bucket_ctrl_if bus();

    hll_bucket_ctrl #(.P(P)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_total   = 0;
    int n_bad     = 0;
    int cyc       = 0;
    int cyc_flush = 0;
    int model [NB];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input longint got, input longint exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Rank = leading zeros of the (32-P)-bit remainder plus one, saturating at 33-P.
    function automatic int ref_rank(input logic [31:0] h);
        longint rem;
        rem = longint'(h) & ((longint'(1) << (32 - P)) - 1);
        if (rem == 0) return 33 - P;
        return (32 - P) - ($clog2(rem + 1) - 1);
    endfunction

    task automatic clear_model();
        for (int i = 0; i < NB; i++) model[i] = 0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_hash_ready"},   bus.hash_ready,   0);
        check({tag, "_busy"},         bus.busy,         1);
        check({tag, "_bucket_valid"}, bus.bucket_valid, 0);
        check({tag, "_bucket_data"},  bus.bucket_data,  0);
        check({tag, "_bucket_last"},  bus.bucket_last,  0);
    endtask

    task automatic beat(input logic [31:0] h, input bit fl);
        int idx, r;
        bus.hash_data  = h;
        bus.hash_valid = 1'b1;
        bus.flush      = fl;
        if (fl) cyc_flush = cyc;
        @(posedge clk); #1;
        bus.hash_valid = 1'b0;
        bus.flush      = 1'b0;
        idx = int'(h >> (32 - P));
        r   = ref_rank(h);
        if (r > model[idx]) model[idx] = r;
        if (fl) check("rdy_fall", bus.hash_ready, 0);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic flush_only();
        bus.flush = 1'b1;
        cyc_flush = cyc;
        @(posedge clk); #1;
        bus.flush = 1'b0;
        check("rdy_fall", bus.hash_ready, 0);
        check("busy_after_flush", bus.busy, 1);
    endtask

    task automatic wait_ready(input string tag);
        int lows = 0;
        while (lows < 200) begin
            @(negedge clk);
            if (bus.hash_ready) break;
            lows++;
        end
        check(tag, lows, 16);
        check({tag, "_busy"}, bus.busy, 0);
        @(posedge clk); #1;
    endtask

    task automatic readout(input bit rnd, input int stop_at, output bit stopped);
        int got = 0;
        int budget = 0;
        bit stalled = 0;
        bit first = 1;
        int hd = 0;
        int hl = 0;
        stopped = 0;
        while (got < NB && budget < 400) begin
            bus.bucket_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge clk);
            if (stalled) begin
                check("hold_valid", bus.bucket_valid, 1);
                check("hold_data",  bus.bucket_data,  hd);
                check("hold_last",  bus.bucket_last,  hl);
            end
            stalled = 0;
            if (bus.bucket_valid) begin
                if (first) begin
                    check("first_valid_lat_le13", (cyc - cyc_flush) <= 13, 1);
                    first = 0;
                end
                if (got == stop_at) begin
                    stopped = 1;
                    return;
                end
                if (bus.bucket_ready) begin
                    check("bkt_data", bus.bucket_data, model[got]);
                    check("bkt_last", bus.bucket_last, got == NB - 1);
                    got++;
                end else begin
                    stalled = 1;
                    hd = bus.bucket_data;
                    hl = bus.bucket_last;
                end
            end
            @(posedge clk); #1;
            budget++;
        end
        bus.bucket_ready = 1'b0;
        check("readout_count", got, NB);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", n_total, n_bad);
        $fatal(1, "watchdog");
    end

    initial begin
        bit stopped;
        bus.hash_data    = '0;
        bus.hash_valid   = 1'b0;
        bus.flush        = 1'b0;
        bus.bucket_ready = 1'b0;
        rst              = 1'b1;

        repeat (3) @(negedge clk);
        check_reset_outputs("por");
        @(posedge clk); #1;
        rst = 1'b0;
        wait_ready("ready_rise_por");

        // Empty dataset: all zeros, then CLEAR reruns.
        clear_model();
        flush_only();
        readout(1'b0, -1, stopped);
        wait_ready("ready_rise_rearm");

        clear_model();
        beat(32'h0000_0000, 1'b0);
        beat(32'hA800_0000, 1'b1);
        readout(1'b0, -1, stopped);
        wait_ready("ready_rise_t2a");

        clear_model();
        beat(32'hA000_0000, 1'b0);
        beat(32'hA400_0000, 1'b1);
        readout(1'b0, -1, stopped);
        wait_ready("ready_rise_t2b");

        // Back-to-back same-bucket updates exercise forwarding and the t+2 RAM path.
        clear_model();
        beat(32'h3100_0000, 1'b0);
        beat(32'h3800_0000, 1'b0);
        beat(32'h3020_0000, 1'b0);
        idle(1);
        beat(32'h3800_0000, 1'b0);
        idle(2);
        flush_only();
        readout(1'b1, -1, stopped);
        wait_ready("ready_rise_t3");

        clear_model();
        for (int i = 0; i < 1000; i++) begin
            logic [31:0] h;
            h = $urandom;
            if ($urandom_range(0, 3) == 0) h[27:0] = h[27:0] >> $urandom_range(0, 28);
            beat(h, i == 999);
        end
        readout(1'b1, -1, stopped);
        wait_ready("ready_rise_t4");

        // Reset in the middle of READ while bucket 7 is presented.
        clear_model();
        for (int i = 0; i < 20; i++) beat($urandom | 32'h0000_0001, i == 19);
        readout(1'b1, 7, stopped);
        check("stop_at_bucket7", stopped, 1);
        rst = 1'b1;
        #1;
        check_reset_outputs("mid_read_rst");
        @(posedge clk); #1;
        rst = 1'b0;
        wait_ready("ready_rise_after_rst");
        clear_model();
        flush_only();
        readout(1'b0, -1, stopped);
        wait_ready("ready_rise_final");

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
